// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer: FSM state encoding and default counter width.
package countdown_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/down_counter_core.sv
// WIDTH-bit down counter register with parallel load, gated decrement and zero detect.
// The counter saturates at zero: a decrement request while the value is 0 is dropped.
module down_counter_core
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] q_o,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign zero_o = (q_q == '0);
  assign q_o    = q_q;

  // NOTE: q_d takes a default before any branch so the block stays purely combinational (no latch).
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_value_i;
    end else if (dec_i && !zero_o) begin
      q_d = q_q - ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/countdown_timer_4_bit.sv
// Loadable countdown timer with valid/ready load handshake, count enable and a one-cycle tc pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to make DONE reload the last loaded value and keep counting.
module countdown_timer_4_bit
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q;
  logic             tc_q;
  logic             handshake;
  logic             q_zero;
  logic             dec_en;
  logic             core_load;
  logic [WIDTH-1:0] core_value;

  // Both flags are pure decodes of the state register, so reset drives them immediately.
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tc         = tc_q;
  assign handshake  = load_valid && load_ready;
  assign dec_en     = (state_q == COUNT) && en && !q_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  assign core_load  = handshake || ((state_q == DONE) && (reload_q != '0));
  assign core_value = handshake ? load_value : reload_q;
`else
  assign core_load  = handshake;
  assign core_value = load_value;
`endif

  down_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (core_load),
    .load_value_i(core_value),
    .dec_i       (dec_en),
    .q_o         (Q),
    .zero_o      (q_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tc_q     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (handshake) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= load_value;
`endif
            if (load_value == '0) begin
              state_q <= DONE;
              tc_q    <= 1'b1;
            end else begin
              state_q <= COUNT;
            end
          end
        end
        COUNT: begin
          if (en && (Q == ONE)) begin
            state_q <= DONE;
            tc_q    <= 1'b1;
          end
        end
        DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          state_q <= (reload_q != '0) ? COUNT : IDLE;
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_4_bit.sv
// Self-checking bench: cycle model of the timer's observable behaviour plus directed literal cases.
module tb_countdown_timer_4_bit;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid, en;
  logic [3:0] load_value;
  logic       load_ready, tc, busy;
  logic [3:0] Q;

  logic       load_valid8, en8;
  logic [7:0] load_value8;
  logic       load_ready8, tc8, busy8;
  logic [7:0] Q8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  countdown_timer_4_bit dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .en(en), .Q(Q), .tc(tc), .busy(busy)
  );

  countdown_timer_4_bit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .load_valid(load_valid8), .load_ready(load_ready8),
    .load_value(load_value8), .en(en8), .Q(Q8), .tc(tc8), .busy(busy8)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model of the 4-bit instance: remaining count, whether a countdown is active,
  // whether this is the terminal cycle, and the last accepted load value.
  int m_q, m_reload;
  bit m_busy, m_tc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = 0; m_reload = 0; m_busy = 0; m_tc = 0;
    end else if (!m_busy) begin
      if (load_valid) begin
        m_q      = int'(load_value);
        m_reload = int'(load_value);
        m_busy   = 1;
        m_tc     = (load_value == 4'd0);
      end
    end else if (m_tc) begin
      m_tc = 0;
      if (AR && m_reload != 0) m_q = m_reload;
      else                     m_busy = 0;
    end else if (en && m_q > 0) begin
      m_q  = m_q - 1;
      m_tc = (m_q == 0);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("model_q", 32'(Q), 32'(m_q));
      check("model_tc", 32'(tc), 32'(m_tc));
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_ready", 32'(load_ready), 32'(!m_busy));
    end
  end

  // Reset, handshake on the first edge after release, then literal Q/tc checks up to the tc sample.
  // Sample i is taken on the falling edge after clock edge E_i (E_0 = handshake edge);
  // en_pat[i] is the enable presented to edge E_(i+1); exp_q nibble i is Q at sample i.
  task automatic run_case(input string nm, input logic [3:0] v, input logic [15:0] en_pat,
                          input logic [63:0] exp_q, input int tc_at, input bit poke);
    @(negedge clk);
    rst = 1'b1; load_valid = 1'b0; en = 1'b0;
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b1; load_value = v;
    for (int i = 0; i <= tc_at; i++) begin
      @(negedge clk);
      load_valid = poke && (i < tc_at);
      load_value = poke ? 4'd9 : v;
      check({nm, "_q"}, 32'(Q), 32'(exp_q[4*i +: 4]));
      check({nm, "_tc"}, 32'(tc), 32'(i == tc_at));
      en = en_pat[i];
    end
    load_valid = 1'b0;
  endtask

  int tc_count;

  initial begin
    rst = 1'b1; load_valid = 1'b0; en = 1'b0; load_value = 4'd0;
    load_valid8 = 1'b0; en8 = 1'b0; load_value8 = 8'd0;

    // Load 5 with en held high: 5,4,3,2,1,0 with tc five clocks after the handshake.
    run_case("load5", 4'd5, 16'hFFFF, 64'h012345, 5, 1'b0);
    @(negedge clk);
    check("load5_after_tc", 32'(tc), 32'(0));
    check("load5_after_busy", 32'(busy), 32'(AR));
    check("load5_after_ready", 32'(load_ready), 32'(!AR));
    check("load5_after_q", 32'(Q), AR ? 32'(5) : 32'(0));

    // Stall: enables 1,0,0,1,1 give 3,2,2,2,1,0.
    run_case("stall", 4'd3, 16'h0019, 64'h012223, 5, 1'b0);

    // Zero load: DONE right after the handshake, Q stays 0, back to idle.
    run_case("zero", 4'd0, 16'hFFFF, 64'h0, 0, 1'b0);
    @(negedge clk);
    check("zero_after_tc", 32'(tc), 32'(0));
    check("zero_after_busy", 32'(busy), 32'(0));
    check("zero_after_q", 32'(Q), 32'(0));

    // load_valid with value 9 during COUNT must not disturb the countdown.
    run_case("ignore", 4'd4, 16'hFFFF, 64'h01234, 4, 1'b1);

    // Periodic mode: load 2, tc every 3 cycles (AR) or once (default).
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b1; load_value = 4'd2;
    tc_count = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      if (tc) tc_count++;
    end
    check("reload_tc_count", 32'(tc_count), AR ? 32'(4) : 32'(1));

    // Asynchronous reset mid-count with Q=2, between clock edges.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b1; load_value = 4'd5; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
    end
    check("async_pre_q", 32'(Q), 32'(2));
    #2 rst = 1'b1;
    #1;
    check("async_q", 32'(Q), 32'(0));
    check("async_busy", 32'(busy), 32'(0));
    check("async_ready", 32'(load_ready), 32'(1));
    check("async_tc", 32'(tc), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    tc_count = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tc) tc_count++;
    end
    check("async_no_tc", 32'(tc_count), 32'(0));

    // WIDTH=8: load 255, tc after 255 enabled cycles, no wrap.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; load_valid8 = 1'b1; load_value8 = 8'd255; en8 = 1'b1;
    for (int i = 0; i <= 255; i++) begin
      @(negedge clk);
      load_valid8 = 1'b0;
      check("w8_q", 32'(Q8), 32'(255 - i));
      check("w8_tc", 32'(tc8), 32'(i == 255));
    end
    @(negedge clk);
    check("w8_after_q", 32'(Q8), AR ? 32'(255) : 32'(0));
    check("w8_after_busy", 32'(busy8), 32'(AR));
    check("w8_after_tc", 32'(tc8), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
